// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch definitions: FSM encoding, opcode bounds, helpers.
// Imported by if_fetch_stage and if_skid_buf.
package legv8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 21;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;

  function automatic logic [31:0] sat_add32(
    input logic [31:0] a,
    input logic [1:0]  b
  );
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// Two-entry OUT/SKID buffer of {instr, pc} toward decode.
// Flush drops both entries; SKID refills OUT on consumption.
module if_skid_buf
  import legv8_pkg::*;
#(
  parameter int IW = 32,
  parameter int AW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          in_valid_i,
  input  logic [IW-1:0] in_instr_i,
  input  logic [AW-1:0] in_pc_i,
  input  logic          out_ready_i,
  output logic          out_valid_o,
  output logic [IW-1:0] out_instr_o,
  output logic [AW-1:0] out_pc_o,
  output logic          skid_valid_o
);

  logic          out_v_q;
  logic          skid_v_q;
  logic [IW-1:0] out_i_q;
  logic [IW-1:0] skid_i_q;
  logic [AW-1:0] out_p_q;
  logic [AW-1:0] skid_p_q;
  logic          pop;

  assign pop = out_v_q && out_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      out_i_q  <= '0;
      skid_i_q <= '0;
      out_p_q  <= '0;
      skid_p_q <= '0;
    end else if (flush_i) begin
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
    end else if (skid_v_q) begin
      if (pop) begin
        out_i_q  <= skid_i_q;
        out_p_q  <= skid_p_q;
        skid_v_q <= in_valid_i;
        if (in_valid_i) begin
          skid_i_q <= in_instr_i;
          skid_p_q <= in_pc_i;
        end
      end
    end else if (in_valid_i) begin
      if (!out_v_q || pop) begin
        out_v_q <= 1'b1;
        out_i_q <= in_instr_i;
        out_p_q <= in_pc_i;
      end else begin
        skid_v_q <= 1'b1;
        skid_i_q <= in_instr_i;
        skid_p_q <= in_pc_i;
      end
    end else if (pop) begin
      out_v_q <= 1'b0;
    end
  end

  assign out_valid_o  = out_v_q;
  assign out_instr_o  = out_i_q;
  assign out_pc_o     = out_p_q;
  assign skid_valid_o = skid_v_q;

endmodule

// File: rtl/if_fetch_stage.sv
// LEGv8 instruction fetch: PC, imem req/ack FSM, branch redirect.
// Define IF_FETCH_PERF_CNT_EN to add fetch/flush counters.
module if_fetch_stage
  import legv8_pkg::*;
#(
  parameter int PC_W = 64,
  parameter int INSTR_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     branch_taken,
  input  logic [PC_W-1:0]          branch_target,
  input  logic                     id_ready,
  output logic                     if_valid,
  output logic [INSTR_W-1:0]       if_instr,
  output logic [PC_W-1:0]          if_pc,
  output logic [OPC_MSB-OPC_LSB:0] if_opcode
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              perf_fetch_cnt,
  output logic [31:0]              perf_flush_cnt
`endif
);

  fetch_state_e     state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  addr_q;
  logic             req_q;
  logic             ack;
  logic             word_v;
  logic             out_v;
  logic             skid_v;
  logic [PC_W-1:0]  tgt;
  logic [INSTR_W-1:0] out_instr;

  assign ack    = imem_ack && req_q;
  assign word_v = ack && (state_q == WAIT) && !branch_taken;
  assign tgt    = branch_target & ~PC_W'(INSTR_BYTES - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      if (branch_taken) begin
        pc_q <= tgt;
      end else if (word_v) begin
        pc_q <= pc_q + PC_W'(INSTR_BYTES);
      end
      unique case (state_q)
        IDLE: begin
          if (!branch_taken && !skid_v) begin
            req_q   <= 1'b1;
            addr_q  <= pc_q;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end else if (branch_taken) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          // stale word: take the ack, discard it
          if (ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  if_skid_buf #(
    .IW (INSTR_W),
    .AW (PC_W)
  ) u_buf (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (branch_taken),
    .in_valid_i   (word_v),
    .in_instr_i   (imem_rdata),
    .in_pc_i      (addr_q),
    .out_ready_i  (id_ready),
    .out_valid_o  (out_v),
    .out_instr_o  (out_instr),
    .out_pc_o     (if_pc),
    .skid_valid_o (skid_v)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = out_v;
  assign if_instr  = out_instr;
  assign if_opcode = out_instr[OPC_MSB:OPC_LSB];

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [1:0]  flush_n;

  // an OUT word taken by decode this cycle is delivered, not flushed
  assign flush_n = 2'(out_v && !id_ready) + 2'(skid_v)
                 + 2'(ack && (state_q == WAIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (word_v) begin
        fetch_cnt_q <= sat_add32(fetch_cnt_q, 2'd1);
      end
      if (branch_taken) begin
        flush_cnt_q <= sat_add32(flush_cnt_q, flush_n);
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
